// File: rtl/mem_wb_reg_pkg.sv
// Shared widths, memory-select encodings and the MEM/WB payload struct.
// Used by mem_wb_reg and mem_wb_reg_load_align.
package mem_wb_reg_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned CP0_ADDR_W = 8;
   localparam int unsigned MEM_SEL_W  = 4;

   localparam logic [MEM_SEL_W-1:0] MEM_SEL_BYTE = 4'b0001;
   localparam logic [MEM_SEL_W-1:0] MEM_SEL_HALF = 4'b0011;
   localparam logic [MEM_SEL_W-1:0] MEM_SEL_WORD = 4'b1111;

   typedef struct packed {
      logic                  mem_read;
      logic                  mem_write;
      logic                  sign_ext;
      logic [MEM_SEL_W-1:0]  sel;
      logic [DATA_W-1:0]     result;
      logic                  reg_we;
      logic [REG_ADDR_W-1:0] reg_addr;
      logic [DATA_W-1:0]     pc;
      logic                  hilo_we;
      logic [DATA_W-1:0]     hi;
      logic [DATA_W-1:0]     lo;
      logic                  cp0_we;
      logic [DATA_W-1:0]     cp0_data;
      logic [CP0_ADDR_W-1:0] cp0_addr;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg_load_align.sv
// Combinational load aligner: picks the byte/half/word lane and extends it.
// Misaligned half/word accesses return zero.
module mem_wb_reg_load_align
   import mem_wb_reg_pkg::*;
(
   input  logic [MEM_SEL_W-1:0] sel,
   input  logic [1:0]           addr_lo,
   input  logic                 sign_ext,
   input  logic [DATA_W-1:0]    word,
   output logic [DATA_W-1:0]    data_c
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c = word[7:0];
      case (addr_lo)
         2'd1:    byte_c = word[15:8];
         2'd2:    byte_c = word[23:16];
         2'd3:    byte_c = word[31:24];
         default: byte_c = word[7:0];
      endcase
      half_c = addr_lo[1] ? word[31:16] : word[15:0];

      data_c = '0;
      case (sel)
         MEM_SEL_BYTE: data_c = sign_ext ? {{(DATA_W-8){byte_c[7]}}, byte_c}
                                         : {{(DATA_W-8){1'b0}}, byte_c};
         MEM_SEL_HALF: begin
            if (!addr_lo[0])
               data_c = sign_ext ? {{(DATA_W-16){half_c[15]}}, half_c}
                                 : {{(DATA_W-16){1'b0}}, half_c};
         end
         MEM_SEL_WORD: begin
            if (addr_lo == 2'd0) data_c = word;
         end
         default: data_c = '0;
      endcase
   end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with flush/bubble/hold control and load alignment.
// Optional MEM_WB_LOAD_HOLD_EN keeps load data alive across WB stalls.
module mem_wb_reg
   import mem_wb_reg_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  stall_current,
   input  logic                  stall_next,
   input  logic                  mem_read_flag_in,
   input  logic                  mem_write_flag_in,
   input  logic                  mem_sign_ext_flag_in,
   input  logic [MEM_SEL_W-1:0]  mem_sel_in,
   input  logic [DATA_W-1:0]     result_in,
   input  logic                  reg_write_en_in,
   input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
   input  logic [DATA_W-1:0]     current_pc_addr_in,
   input  logic                  hilo_write_en_in,
   input  logic [DATA_W-1:0]     hi_in,
   input  logic [DATA_W-1:0]     lo_in,
   input  logic                  cp0_write_en_in,
   input  logic [DATA_W-1:0]     cp0_write_data_in,
   input  logic [CP0_ADDR_W-1:0] cp0_addr_in,
   input  logic [DATA_W-1:0]     ram_read_data,
   output logic                  reg_write_en_out,
   output logic [REG_ADDR_W-1:0] reg_write_addr_out,
   output logic [DATA_W-1:0]     reg_write_data_out,
   output logic [DATA_W-1:0]     current_pc_addr_out,
   output logic                  hilo_write_en_out,
   output logic [DATA_W-1:0]     hi_out,
   output logic [DATA_W-1:0]     lo_out,
   output logic                  cp0_write_en_out,
   output logic [DATA_W-1:0]     cp0_write_data_out,
   output logic [CP0_ADDR_W-1:0] cp0_addr_out
);

   mem_wb_t           in_c;
   mem_wb_t           pipe_d, pipe_q;
   logic              fresh_d, fresh_q;
   logic [DATA_W-1:0] load_word_c;
   logic [DATA_W-1:0] aligned_c;
`ifdef MEM_WB_LOAD_HOLD_EN
   logic [DATA_W-1:0] hold_d, hold_q;
   logic              held_d, held_q;
`endif

   always_comb begin
      in_c          = '0;
      in_c.mem_read  = mem_read_flag_in;
      in_c.mem_write = mem_write_flag_in;
      in_c.sign_ext  = mem_sign_ext_flag_in;
      in_c.sel       = mem_sel_in;
      in_c.result    = result_in;
      in_c.reg_we    = reg_write_en_in;
      in_c.reg_addr  = reg_write_addr_in;
      in_c.pc        = current_pc_addr_in;
      in_c.hilo_we   = hilo_write_en_in;
      in_c.hi        = hi_in;
      in_c.lo        = lo_in;
      in_c.cp0_we    = cp0_write_en_in;
      in_c.cp0_data  = cp0_write_data_in;
      in_c.cp0_addr  = cp0_addr_in;
   end

   // Priority: flush > bubble > capture > hold; fresh lives for one edge only.
   always_comb begin
      pipe_d  = pipe_q;
      fresh_d = 1'b0;
`ifdef MEM_WB_LOAD_HOLD_EN
      hold_d  = hold_q;
      held_d  = held_q;
`endif
      if (flush || (stall_current && !stall_next)) begin
         pipe_d = '0;
`ifdef MEM_WB_LOAD_HOLD_EN
         hold_d = '0;
         held_d = 1'b0;
`endif
      end else if (!stall_current) begin
         pipe_d  = in_c;
         fresh_d = mem_read_flag_in;
`ifdef MEM_WB_LOAD_HOLD_EN
         held_d  = 1'b0;
`endif
      end else begin
`ifdef MEM_WB_LOAD_HOLD_EN
         // RAM data is only valid the cycle after capture; latch it before it goes stale.
         if (fresh_q) begin
            hold_d = ram_read_data;
            held_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q  <= '0;
         fresh_q <= 1'b0;
`ifdef MEM_WB_LOAD_HOLD_EN
         hold_q  <= '0;
         held_q  <= 1'b0;
`endif
      end else begin
         pipe_q  <= pipe_d;
         fresh_q <= fresh_d;
`ifdef MEM_WB_LOAD_HOLD_EN
         hold_q  <= hold_d;
         held_q  <= held_d;
`endif
      end
   end

`ifdef MEM_WB_LOAD_HOLD_EN
   assign load_word_c = held_q ? hold_q : ram_read_data;
   logic unused_store_c;
   assign unused_store_c = pipe_q.mem_write;
`else
   assign load_word_c = ram_read_data;
   logic unused_store_c;
   assign unused_store_c = pipe_q.mem_write ^ fresh_q;
`endif

   mem_wb_reg_load_align u_load_align (
      .sel      (pipe_q.sel),
      .addr_lo  (pipe_q.result[1:0]),
      .sign_ext (pipe_q.sign_ext),
      .word     (load_word_c),
      .data_c   (aligned_c)
   );

   assign reg_write_en_out    = pipe_q.reg_we;
   assign reg_write_addr_out  = pipe_q.reg_addr;
   assign reg_write_data_out  = pipe_q.mem_read ? aligned_c : pipe_q.result;
   assign current_pc_addr_out = pipe_q.pc;
   assign hilo_write_en_out   = pipe_q.hilo_we;
   assign hi_out              = pipe_q.hi;
   assign lo_out              = pipe_q.lo;
   assign cp0_write_en_out    = pipe_q.cp0_we;
   assign cp0_write_data_out  = pipe_q.cp0_data;
   assign cp0_addr_out        = pipe_q.cp0_addr;

endmodule
